// File: rtl/sequence_player.sv
// Memory-mapped color-sequence player: stores to address 10 queue colors, address 11
// starts playback or clears; each color is shown for ON_CYCLES then dark for GAP_CYCLES.
module sequence_player #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ON_CYCLES  = 25000000,
    parameter int unsigned GAP_CYCLES = 12500000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        wEn,
    input  logic [11:0] addr,
    input  logic [31:0] dataIn,
    output logic [31:0] dataOut,
    output logic [1:0]  color,
    output logic        active,
    output logic        busy,
    output logic        done
);

    localparam int unsigned PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW   = PW + 1;
    localparam int unsigned TMAX = (ON_CYCLES > GAP_CYCLES) ? ON_CYCLES : GAP_CYCLES;
    localparam int unsigned TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [11:0] ADDR_DATA = 12'd10;
    localparam logic [11:0] ADDR_CTRL = 12'd11;

    typedef enum logic [1:0] {S_IDLE, S_ON, S_GAP} state_e;

    state_e          state_q, state_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [PW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            ovf_q, ovf_d;
    logic [1:0]      color_q, color_d;
    logic            active_q, active_d, busy_q, busy_d, done_q, done_d;
    logic [1:0]      mem_q [DEPTH];

    logic wr_data, wr_ctrl, do_clear, do_start, empty, full;
    logic pop, push_ok, finish;
    logic unused_data;

    // Store decode; clear wins over start when both bits are set
    assign wr_data  = wEn && (addr == ADDR_DATA);
    assign wr_ctrl  = wEn && (addr == ADDR_CTRL);
    assign do_clear = wr_ctrl && dataIn[1];
    assign do_start = wr_ctrl && !dataIn[1] && dataIn[0];
    assign empty    = (cnt_q == '0);
    assign full     = (cnt_q == CW'(DEPTH));
    assign unused_data = ^dataIn[31:2];

    // State and datapath registers
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= S_IDLE;
            timer_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            cnt_q    <= '0;
            ovf_q    <= 1'b0;
            color_q  <= 2'b00;
            active_q <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            cnt_q    <= cnt_d;
            ovf_q    <= ovf_d;
            color_q  <= color_d;
            active_q <= active_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    // Queue storage needs no reset: occupancy alone defines validity
    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem_q[wr_ptr_q] <= dataIn[1:0];
        end
    end

    // Next state, phase timer and queue bookkeeping
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        pop      = 1'b0;
        finish   = 1'b0;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        cnt_d    = cnt_q;
        ovf_d    = ovf_q;
        push_ok  = 1'b0;

        if (do_clear) begin
            state_d = S_IDLE;
            timer_d = '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (do_start && !empty) begin
                        state_d = S_ON;
                        timer_d = '0;
                        pop     = 1'b1;
                    end
                end
                S_ON: begin
                    if (timer_q == TW'(ON_CYCLES - 1)) begin
                        state_d = S_GAP;
                        timer_d = '0;
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                S_GAP: begin
                    if (timer_q == TW'(GAP_CYCLES - 1)) begin
                        timer_d = '0;
                        if (!empty) begin
                            state_d = S_ON;
                            pop     = 1'b1;
                        end else begin
                            state_d = S_IDLE;
                            finish  = 1'b1;
                        end
                    end else begin
                        timer_d = timer_q + TW'(1);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (do_clear) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
            ovf_d    = 1'b0;
        end else begin
            // A pop in the same cycle frees the slot for a push to a full queue
            push_ok = wr_data && (!full || pop);
            if (wr_data && !push_ok) begin
                ovf_d = 1'b1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            if (push_ok) begin
                wr_ptr_d = wr_ptr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
        end
    end

    // Registered output values
    always_comb begin
        color_d  = color_q;
        active_d = (state_d == S_ON);
        busy_d   = (state_d != S_IDLE);
        done_d   = finish;
        if (pop) begin
            color_d = mem_q[rd_ptr_q];
        end
    end

    assign color  = color_q;
    assign active = active_q;
    assign busy   = busy_q;
    assign done   = done_q;

    // Status read is a combinational decode of registered fields
    assign dataOut = (addr == ADDR_DATA) ? {22'b0, ovf_q, busy_q, 8'(cnt_q)} : 32'b0;

endmodule

// File: tb/tb_sequence_player.sv
// Randomized and directed bench for sequence_player with a queue-based reference model
// feeding a per-cycle scoreboard.
module tb_sequence_player;

    localparam int unsigned DEPTH = 4;
    localparam int unsigned ON_C  = 4;
    localparam int unsigned GAP_C = 2;

    logic        clock = 1'b0;
    logic        reset;
    logic        wEn;
    logic [11:0] addr;
    logic [31:0] dataIn;
    logic [31:0] dataOut;
    logic [1:0]  color;
    logic        active, busy, done;

    sequence_player #(.DEPTH(DEPTH), .ON_CYCLES(ON_C), .GAP_CYCLES(GAP_C)) dut (
        .clock(clock), .reset(reset), .wEn(wEn), .addr(addr), .dataIn(dataIn),
        .dataOut(dataOut), .color(color), .active(active), .busy(busy), .done(done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [1:0] color;
        logic       active;
        logic       busy;
        logic       done;
        logic       ovf;
        logic [2:0] occ;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic void check(input string name, input logic [36:0] act, input logic [36:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s @%0t: got %h expected %h", name, $time, act, exp);
        end
    endfunction

    // Reference model: colors in a queue, phase plus cycles remaining in that phase
    int unsigned m_mode;   // 0 idle, 1 showing, 2 dark
    int unsigned m_left;
    logic [1:0]  m_color;
    bit          m_done, m_ovf;
    logic [1:0]  mq[$];

    always @(posedge clock) begin
        exp_t e;
        bit clr, strt, psh;
        if (!reset) begin
            mq.delete();
            m_mode = 0; m_left = 0; m_color = 2'b00; m_done = 0; m_ovf = 0;
        end else begin
            clr  = wEn && addr == 12'd10 + 12'd1 && dataIn[1];
            strt = wEn && addr == 12'd11 && !dataIn[1] && dataIn[0];
            psh  = wEn && addr == 12'd10;
            m_done = 0;
            if (clr) begin
                mq.delete();
                m_ovf  = 0;
                m_mode = 0;
            end else begin
                if (m_mode == 0) begin
                    if (strt && mq.size() > 0) begin
                        m_color = mq.pop_front(); m_mode = 1; m_left = ON_C;
                    end
                end else begin
                    m_left--;
                    if (m_left == 0) begin
                        if (m_mode == 1) begin
                            m_mode = 2; m_left = GAP_C;
                        end else if (mq.size() > 0) begin
                            m_color = mq.pop_front(); m_mode = 1; m_left = ON_C;
                        end else begin
                            m_mode = 0; m_done = 1;
                        end
                    end
                end
                if (psh) begin
                    if (mq.size() < DEPTH) mq.push_back(dataIn[1:0]);
                    else m_ovf = 1;
                end
            end
        end
        e.color  = m_color;
        e.active = (m_mode == 1);
        e.busy   = (m_mode != 0);
        e.done   = m_done;
        e.ovf    = m_ovf;
        e.occ    = 3'(mq.size());
        sb.push_back(e);
    end

    // Monitor: one expected sample per cycle, compared away from the active edge
    always @(negedge clock) begin
        exp_t e;
        logic [31:0] exp_do;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            exp_do = (addr == 12'd10) ? {22'b0, e.ovf, e.busy, 5'b0, e.occ} : 32'b0;
            check("cycle", {color, active, busy, done, dataOut},
                  {e.color, e.active, e.busy, e.done, exp_do});
        end
    end

    task automatic store(input logic [11:0] a, input logic [1:0] lo, input bit hi_rand);
        logic [31:0] d;
        d = hi_rand ? $urandom : 32'b0;
        d[1:0] = lo;
        wEn = 1'b1; addr = a; dataIn = d;
        @(posedge clock); #1;
        wEn = 1'b0; addr = 12'd10;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            wEn = 1'b0;
            addr = ($urandom_range(0, 1) == 1) ? 12'd10 : 12'($urandom);
            dataIn = $urandom;
            @(posedge clock); #1;
        end
        addr = 12'd10;
    endtask

    task automatic async_reset_check(input string name);
        @(negedge clock); #1;
        reset = 1'b0;
        #1;
        check(name, {color, active, busy, done, dataOut}, 37'b0);
        @(posedge clock); @(posedge clock); #1;
        check({name, "_held"}, {color, active, busy, done, dataOut}, 37'b0);
        reset = 1'b1;
    endtask

    initial begin
        logic [11:0] a;
        int r;
        reset = 1'b0; wEn = 1'b0; addr = 12'd10; dataIn = 32'b0;
        #3;
        check("reset_out", {color, active, busy, done, dataOut}, 37'b0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;

        // Two-color run
        store(12'd10, 2'b01, 1); store(12'd10, 2'b10, 1); store(12'd11, 2'b01, 0);
        idle(16);
        // Overflow, play four, then clear
        store(12'd10, 2'b00, 1); store(12'd10, 2'b01, 1); store(12'd10, 2'b10, 1);
        store(12'd10, 2'b11, 1); store(12'd10, 2'b01, 1);
        idle(2);
        store(12'd11, 2'b01, 0);
        idle(26);
        store(12'd11, 2'b10, 0);
        idle(2);
        // Push during first ON of a single-entry run
        store(12'd10, 2'b00, 1); store(12'd11, 2'b01, 0);
        idle(1);
        store(12'd10, 2'b11, 1);
        idle(14);
        // Start on empty queue, start while busy
        store(12'd11, 2'b01, 0); idle(3);
        store(12'd10, 2'b10, 1); store(12'd11, 2'b01, 0); idle(2);
        store(12'd11, 2'b01, 0); idle(10);
        // Unrelated addresses and wEn=0 stores
        store(12'h40A, 2'b01, 1); store(12'd9, 2'b10, 1); store(12'd12, 2'b11, 1);
        idle(3);
        // Clear mid-ON with start bit also set
        store(12'd10, 2'b01, 1); store(12'd10, 2'b10, 1); store(12'd11, 2'b01, 0);
        idle(2);
        store(12'd11, 2'b11, 0);
        idle(3);
        // Reset mid-GAP with two entries queued
        store(12'd10, 2'b11, 1); store(12'd10, 2'b00, 1); store(12'd10, 2'b01, 1);
        store(12'd11, 2'b01, 0);
        idle(5);
        async_reset_check("reset_mid_gap");
        idle(3);

        // Random traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 99);
            if (r < 35) store(12'd10, 2'($urandom), 1);
            else if (r < 45) store(12'd11, 2'b01, 1'b0);
            else if (r < 48) store(12'd11, {1'b1, 1'($urandom)}, 1);
            else if (r < 53) begin
                a = 12'($urandom);
                if (a == 12'd10 || a == 12'd11) a = 12'd12;
                store(a, 2'($urandom), 1);
            end else idle(1);
        end
        idle(30);
        @(negedge clock); #1;
        check("drain", 37'(sb.size()), 37'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
